// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_pkg
// Brief    : Shared types and constants for the multi-cycle MEM pipeline stage
//            (branch condition codes, FSM state encoding, m_ctl bit indices).
// Revision : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

  // Branch condition codes carried on bcond
  typedef enum logic [2:0] {
    EQ     = 3'd0,
    LT     = 3'd1,
    GT     = 3'd2,
    OV     = 3'd3,
    NE     = 3'd4,
    GE     = 3'd5,
    LE     = 3'd6,
    UNCOND = 3'd7
  } cond_e;

  // Stage controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // m_ctl bit positions
  localparam int c_mctl_rd = 0;
  localparam int c_mctl_wr = 1;
  localparam int c_mctl_br = 2;

  // flags_in bit positions
  localparam int c_flg_zr  = 0;
  localparam int c_flg_neg = 1;
  localparam int c_flg_ov  = 2;

endpackage : mem_stage_pkg
`default_nettype wire

// File: rtl/mem_stage_mc_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_unit
// Brief    : Combinational branch resolution from ALU flags and condition code.
//            Output is forced low for non-branch instructions.
// Revision : 1.0 - initial release
// ============================================================================
module branch_unit
  import mem_stage_pkg::*;
(
  input  logic [2:0] flags,
  input  logic [2:0] bcond,
  input  logic       branch,
  output logic       taken
);

  logic w_zr;
  logic w_neg;
  logic w_ov;
  logic w_cond;

  assign w_zr  = flags[c_flg_zr];
  assign w_neg = flags[c_flg_neg];
  assign w_ov  = flags[c_flg_ov];

  // Evaluate the selected condition; every code has a defined result
  always_comb begin
    w_cond = 1'b0;
    case (cond_e'(bcond))
      EQ:      w_cond = w_zr;
      LT:      w_cond = w_neg & ~w_ov;
      GT:      w_cond = ~w_neg & ~w_zr;
      OV:      w_cond = w_ov;
      NE:      w_cond = ~w_zr;
      GE:      w_cond = ~w_neg;
      LE:      w_cond = w_neg | w_zr;
      UNCOND:  w_cond = 1'b1;
      default: w_cond = 1'b0;
    endcase
  end

  assign taken = branch & w_cond;

endmodule : branch_unit
`default_nettype wire

// File: rtl/mem_stage_mc.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_mc
// Brief    : Multi-cycle MEM pipeline stage. Accepts one op from EX/MEM,
//            performs an optional memory access with a req/ack handshake,
//            resolves the branch and presents the result to WB until taken.
//            Optional feature macro: MEM_STAGE_TIMEOUT_EN (mem_ack timeout,
//            adds the mem_err port).
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_mc
  import mem_stage_pkg::*;
#(
  parameter int DW          = 16,
  parameter int AW          = 16,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    m_ctl,
  input  logic [1:0]    wb_in,
  input  logic [2:0]    flags_in,
  input  logic [2:0]    bcond,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] pc_branch_in,
  input  logic [DW-1:0] alu_in,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] rdata,
  output logic [DW-1:0] alu,
  output logic [1:0]    wb,
  output logic [AW-1:0] pc_branch,
  output logic [AW-1:0] pc_ret,
  output logic          branch_taken
`ifdef MEM_STAGE_TIMEOUT_EN
  ,
  output logic          mem_err
`endif
);

  localparam logic [1:0] c_st_idle   = IDLE;
  localparam logic [1:0] c_st_access = ACCESS;
  localparam logic [1:0] c_st_done   = DONE;

  // A zero timeout would make the ACCESS state meaningless
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("mem_stage_mc: TIMEOUT_CYC must be at least 1");
  end

  logic [1:0]    r_state;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic [DW-1:0] r_alu;
  logic [1:0]    r_wb;
  logic [AW-1:0] r_pcb;
  logic          r_taken;

  logic w_idle;
  logic w_access;
  logic w_done;
  logic w_xfer;
  logic w_is_mem;
  logic w_taken;
  logic w_tmo;

  assign w_idle   = (r_state == c_st_idle);
  assign w_access = (r_state == c_st_access);
  assign w_done   = (r_state == c_st_done);

  assign in_ready = w_idle | (w_done & out_ready);
  assign w_xfer   = in_valid & in_ready;
  assign w_is_mem = m_ctl[c_mctl_rd] | m_ctl[c_mctl_wr];

  // Branch outcome is resolved from the incoming flags at transfer time
  branch_unit u_branch_unit (
    .flags  (flags_in),
    .bcond  (bcond),
    .branch (m_ctl[c_mctl_br]),
    .taken  (w_taken)
  );

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int c_cnt_w = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [c_cnt_w-1:0] r_tmo_cnt;
  logic               r_err;

  // Last permitted ACCESS cycle reached without an acknowledge
  assign w_tmo = (r_tmo_cnt == c_cnt_w'(TIMEOUT_CYC - 1));

  // Count ACCESS cycles; cleared whenever a new op is taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt <= '0;
    end else if (w_xfer) begin
      r_tmo_cnt <= '0;
    end else if (w_access && !mem_ack && !w_tmo) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // Error flag lives for the DONE beat of a timed-out op only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_xfer) begin
      r_err <= 1'b0;
    end else if (w_access && !mem_ack && w_tmo) begin
      r_err <= 1'b1;
    end else if (w_done && out_ready) begin
      r_err <= 1'b0;
    end
  end

  assign mem_err = r_err;
`else
  assign w_tmo = 1'b0;
`endif

  // Stage controller plus capture of the op and of the read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_st_idle;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_alu   <= '0;
      r_wb    <= '0;
      r_pcb   <= '0;
      r_taken <= 1'b0;
    end else if (w_xfer) begin
      r_we    <= m_ctl[c_mctl_wr];
      r_addr  <= addr;
      r_wdata <= wdata;
      r_rdata <= '0;
      r_alu   <= alu_in;
      r_wb    <= wb_in;
      r_pcb   <= pc_branch_in;
      r_taken <= w_taken;
      r_state <= w_is_mem ? c_st_access : c_st_done;
    end else if (w_access) begin
      if (mem_ack) begin
        if (!r_we) begin
          r_rdata <= mem_rdata;
        end
        r_state <= c_st_done;
      end else if (w_tmo) begin
        r_rdata <= '0;
        r_state <= c_st_done;
      end
    end else if (w_done && out_ready) begin
      r_state <= c_st_idle;
    end
  end

  assign mem_req      = w_access;
  assign mem_we       = w_access & r_we;
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign out_valid    = w_done;
  assign rdata        = r_rdata;
  assign alu          = r_alu;
  assign wb           = r_wb;
  assign pc_branch    = r_pcb;
  assign pc_ret       = r_rdata[AW-1:0];
  assign branch_taken = r_taken;

endmodule : mem_stage_mc
`default_nettype wire

// File: tb/tb_mem_stage_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_mc
// Brief    : Self-checking bench for mem_stage_mc (directed plus random ops
//            against a behavioural expectation model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_mc;
  import mem_stage_pkg::*;

  localparam int c_tmo = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  m_ctl;
  logic [1:0]  wb_in;
  logic [2:0]  flags_in;
  logic [2:0]  bcond;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] pc_branch_in;
  logic [15:0] alu_in;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] rdata;
  logic [15:0] alu;
  logic [1:0]  wb;
  logic [15:0] pc_branch;
  logic [15:0] pc_ret;
  logic        branch_taken;
`ifdef MEM_STAGE_TIMEOUT_EN
  logic        mem_err;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage_mc #(.DW(16), .AW(16), .TIMEOUT_CYC(c_tmo)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .m_ctl        (m_ctl),
    .wb_in        (wb_in),
    .flags_in     (flags_in),
    .bcond        (bcond),
    .addr         (addr),
    .wdata        (wdata),
    .pc_branch_in (pc_branch_in),
    .alu_in       (alu_in),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .rdata        (rdata),
    .alu          (alu),
    .wb           (wb),
    .pc_branch    (pc_branch),
    .pc_ret       (pc_ret),
    .branch_taken (branch_taken)
`ifdef MEM_STAGE_TIMEOUT_EN
    ,
    .mem_err      (mem_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Branch truth table indexed by condition code
  function automatic logic exp_taken(input logic br, input logic [2:0] bc, input logic [2:0] fl);
    logic       zr, ng, ov;
    logic [7:0] tbl;
    zr  = fl[0];
    ng  = fl[1];
    ov  = fl[2];
    tbl = {1'b1, ng | zr, ~ng, ~zr, ov, ~ng & ~zr, ng & ~ov, zr};
    return br & tbl[bc];
  endfunction

  task automatic scramble_inputs();
    m_ctl        = 3'($urandom);
    wb_in        = 2'($urandom);
    flags_in     = 3'($urandom);
    bcond        = 3'($urandom);
    addr         = 16'($urandom);
    wdata        = 16'($urandom);
    pc_branch_in = 16'($urandom);
    alu_in       = 16'($urandom);
  endtask

  // One complete op from IDLE back to IDLE, checking every phase
  task automatic run_op(input logic [2:0] mc, input logic [2:0] fl, input logic [2:0] bc,
                        input logic [15:0] a, input logic [15:0] wd, input logic [15:0] pcb,
                        input logic [15:0] av, input logic [1:0] wbv,
                        input int waits, input logic [15:0] rd, input int hold);
    logic        is_mem, is_wr, exp_bt;
    logic [15:0] exp_rd;
    is_mem = mc[0] | mc[1];
    is_wr  = mc[1];
    exp_bt = exp_taken(mc[2], bc, fl);
    exp_rd = (is_mem && !is_wr) ? rd : 16'h0;

    m_ctl = mc; flags_in = fl; bcond = bc; addr = a; wdata = wd;
    pc_branch_in = pcb; alu_in = av; wb_in = wbv;
    in_valid = 1'b1; out_ready = 1'b0;
    #1 chk("in_ready_idle", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    scramble_inputs();
    if (is_mem) begin
      for (int i = 0; i < waits; i++) begin
        chk("mem_req_wait", mem_req, 1'b1);
        chk("mem_addr", mem_addr, a);
        chk("mem_we", mem_we, is_wr);
        chk("mem_wdata", mem_wdata, wd);
        chk("out_valid_wait", out_valid, 1'b0);
        @(negedge clk);
      end
      chk("mem_req_ack", mem_req, 1'b1);
      mem_ack = 1'b1; mem_rdata = rd;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 16'($urandom);
    end
    chk("out_valid", out_valid, 1'b1);
    chk("mem_req_done", mem_req, 1'b0);
    chk("in_ready_done", in_ready, 1'b0);
    chk("rdata", rdata, exp_rd);
    chk("pc_ret", pc_ret, exp_rd);
    chk("alu", alu, av);
    chk("wb", wb, wbv);
    chk("pc_branch", pc_branch, pcb);
    chk("branch_taken", branch_taken, exp_bt);
`ifdef MEM_STAGE_TIMEOUT_EN
    chk("mem_err_clear", mem_err, 1'b0);
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_alu", alu, av);
      chk("hold_rdata", rdata, exp_rd);
    end
    out_ready = 1'b1;
    #1 chk("in_ready_drain", in_ready, 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_after", out_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0;
    m_ctl = 3'b0; wb_in = 2'b0; flags_in = 3'b0; bcond = 3'b0;
    addr = 16'h0; wdata = 16'h0; pc_branch_in = 16'h0; alu_in = 16'h0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_taken", branch_taken, 1'b0);
    chk("rst_rdata", rdata, 16'h0);
    chk("rst_alu", alu, 16'h0);
    chk("rst_wb", wb, 2'h0);
    chk("rst_pcb", pc_branch, 16'h0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_mem_wdata", mem_wdata, 16'h0);
`ifdef MEM_STAGE_TIMEOUT_EN
    chk("rst_mem_err", mem_err, 1'b0);
`endif
    rst = 1'b1;
    @(negedge clk);

    // ALU-only op: result one cycle after transfer
    run_op(3'b000, 3'b000, 3'd0, 16'h0, 16'h0, 16'h0, 16'h1234, 2'b01, 0, 16'h0, 0);
    chk("alu_direct", alu, 16'h1234);

    // Read with three wait cycles
    run_op(3'b001, 3'b000, 3'd0, 16'h0040, 16'h0, 16'h0, 16'h0, 2'b10, 3, 16'hBEEF, 0);
    chk("pc_ret_direct", pc_ret, 16'hBEEF);

    // Write, and read+write treated as a write
    run_op(3'b010, 3'b000, 3'd0, 16'h0100, 16'hA5A5, 16'h0, 16'h0, 2'b00, 1, 16'h7777, 0);
    run_op(3'b011, 3'b000, 3'd0, 16'h0200, 16'h5A5A, 16'h0, 16'h0, 2'b11, 2, 16'h6666, 1);

    // Branch conditions
    run_op(3'b100, 3'b010, LE, 16'h0, 16'h0, 16'h3000, 16'h0, 2'b00, 0, 16'h0, 0);
    chk("br_le_taken", branch_taken, 1'b1);
    run_op(3'b100, 3'b001, GT, 16'h0, 16'h0, 16'h3004, 16'h0, 2'b00, 0, 16'h0, 0);
    chk("br_gt_not", branch_taken, 1'b0);
    run_op(3'b000, 3'b000, UNCOND, 16'h0, 16'h0, 16'h3008, 16'h0, 2'b00, 0, 16'h0, 0);
    chk("br_nobranch", branch_taken, 1'b0);

    // Back-pressure then zero-bubble acceptance
    m_ctl = 3'b000; alu_in = 16'hAAAA; wb_in = 2'b01; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    alu_in = 16'hBBBB; wb_in = 2'b10;
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_alu", alu, 16'hAAAA);
      chk("bp_in_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("b2b_in_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_valid", out_valid, 1'b1);
    chk("b2b_alu", alu, 16'hBBBB);
    chk("b2b_wb", wb, 2'b10);
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_idle", out_valid, 1'b0);

    // Randomized ops
    for (int n = 0; n < 40; n++) begin
      run_op(3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom), 16'($urandom),
             16'($urandom), 16'($urandom), 2'($urandom), int'($urandom_range(0, 2)),
             16'($urandom), int'($urandom_range(0, 2)));
    end

    // Stray ack while idle is ignored
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_ack", out_valid, 1'b0);

    // Reset in the middle of an access
    m_ctl = 3'b001; addr = 16'h0080; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_req_before", mem_req, 1'b1);
    rst = 1'b0;
    #1 chk("mid_req_async", mem_req, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack_valid", out_valid, 1'b0);
    chk("late_ack_rdata", rdata, 16'h0);
    @(negedge clk);
    chk("late_ack_valid2", out_valid, 1'b0);

`ifdef MEM_STAGE_TIMEOUT_EN
    // No ack: give up after c_tmo ACCESS cycles
    m_ctl = 3'b001; addr = 16'h00C0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < c_tmo; i++) begin
      chk("tmo_req", mem_req, 1'b1);
      chk("tmo_err_low", mem_err, 1'b0);
      @(negedge clk);
    end
    chk("tmo_valid", out_valid, 1'b1);
    chk("tmo_err", mem_err, 1'b1);
    chk("tmo_req_off", mem_req, 1'b0);
    chk("tmo_rdata", rdata, 16'h0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("tmo_err_after", mem_err, 1'b0);
    chk("tmo_idle", out_valid, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_stage_mc
`default_nettype wire
